// File: rtl/id_exe_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_exe_pipe_reg
//
// Pipeline register between the Instruction Decode and Execution stages.
// It captures the decoded control bits, the operand values, the shifter
// operand and the branch immediate on every rising clock edge. The captured
// values drive the Execution-stage inputs for one cycle.
//
// Edge priority is rst > flush > freeze > load.
//   rst / flush : every output clears, which forms a bubble.
//   freeze      : every output holds its current value.
//   load        : every output takes its input. When valid_in is low, the
//                 control bits are cleared and the data fields still load.
//
// Optional build macro: ID_EXE_FWD_SRC_EN
//   defined   : src1_out/src2_out are registered like the data fields, and
//               they are cleared on a bubble load.
//   undefined : src1_out/src2_out are tied to 0, and src1_in/src2_in are ignored.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   freeze, flush            hazard stall, taken-branch squash
//   valid_in                 ID stage holds a real instruction
//   pc_in .. status_in       decoded instruction fields (see widths below)
//   src1_in, src2_in         source register numbers (optional feature)
//   *_out                    registered copies of the inputs
//   is_mem_out               registered (mem_r_en | mem_w_en)
// -----------------------------------------------------------------------------
module id_exe_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int SHOP_W  = 12,
    parameter int IMM24_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               valid_in,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic [DATA_W-1:0]  val_rn_in,
    input  logic [DATA_W-1:0]  val_rm_in,
    input  logic [SHOP_W-1:0]  shift_operand_in,
    input  logic               imm_in,
    input  logic [IMM24_W-1:0] signed_imm_24_in,
    input  logic [3:0]         dest_in,
    input  logic [3:0]         exe_cmd_in,
    input  logic               mem_r_en_in,
    input  logic               mem_w_en_in,
    input  logic               wb_en_in,
    input  logic               b_in,
    input  logic               s_in,
    input  logic [3:0]         status_in,
    input  logic [3:0]         src1_in,
    input  logic [3:0]         src2_in,
    output logic [DATA_W-1:0]  pc_out,
    output logic [DATA_W-1:0]  val_rn_out,
    output logic [DATA_W-1:0]  val_rm_out,
    output logic [SHOP_W-1:0]  shift_operand_out,
    output logic               imm_out,
    output logic [IMM24_W-1:0] signed_imm_24_out,
    output logic [3:0]         dest_out,
    output logic [3:0]         exe_cmd_out,
    output logic               mem_r_en_out,
    output logic               mem_w_en_out,
    output logic               wb_en_out,
    output logic               b_out,
    output logic               s_out,
    output logic [3:0]         status_out,
    output logic               valid_out,
    output logic               is_mem_out,
    output logic [3:0]         src1_out,
    output logic [3:0]         src2_out
);

    // Control bits to load this edge. They are qualified by valid_in so that
    // a bubble can never carry a side effect into EXE.
    logic ld_mem_r_en_s;
    logic ld_mem_w_en_s;
    logic ld_wb_en_s;
    logic ld_b_s;
    logic ld_s_s;
    logic ld_is_mem_s;

    // Qualify the incoming control bits with valid_in.
    always_comb begin
        ld_mem_r_en_s = valid_in & mem_r_en_in;
        ld_mem_w_en_s = valid_in & mem_w_en_in;
        ld_wb_en_s    = valid_in & wb_en_in;
        ld_b_s        = valid_in & b_in;
        ld_s_s        = valid_in & s_in;
        ld_is_mem_s   = valid_in & (mem_r_en_in | mem_w_en_in);
    end

    // Main pipeline register. Reset and flush share the bubble branch.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pc_out            <= {DATA_W{1'b0}};
            val_rn_out        <= {DATA_W{1'b0}};
            val_rm_out        <= {DATA_W{1'b0}};
            shift_operand_out <= {SHOP_W{1'b0}};
            imm_out           <= 1'b0;
            signed_imm_24_out <= {IMM24_W{1'b0}};
            dest_out          <= 4'd0;
            exe_cmd_out       <= 4'd0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            wb_en_out         <= 1'b0;
            b_out             <= 1'b0;
            s_out             <= 1'b0;
            status_out        <= 4'd0;
            valid_out         <= 1'b0;
            is_mem_out        <= 1'b0;
        end else if (!freeze) begin
            pc_out            <= pc_in;
            val_rn_out        <= val_rn_in;
            val_rm_out        <= val_rm_in;
            shift_operand_out <= shift_operand_in;
            imm_out           <= imm_in;
            signed_imm_24_out <= signed_imm_24_in;
            dest_out          <= dest_in;
            exe_cmd_out       <= exe_cmd_in;
            mem_r_en_out      <= ld_mem_r_en_s;
            mem_w_en_out      <= ld_mem_w_en_s;
            wb_en_out         <= ld_wb_en_s;
            b_out             <= ld_b_s;
            s_out             <= ld_s_s;
            status_out        <= status_in;
            valid_out         <= valid_in;
            is_mem_out        <= ld_is_mem_s;
        end else begin
            // Freeze: every output holds its value. This also applies to a
            // bubble that was inserted while freeze was high.
            pc_out            <= pc_out;
            val_rn_out        <= val_rn_out;
            val_rm_out        <= val_rm_out;
            shift_operand_out <= shift_operand_out;
            imm_out           <= imm_out;
            signed_imm_24_out <= signed_imm_24_out;
            dest_out          <= dest_out;
            exe_cmd_out       <= exe_cmd_out;
            mem_r_en_out      <= mem_r_en_out;
            mem_w_en_out      <= mem_w_en_out;
            wb_en_out         <= wb_en_out;
            b_out             <= b_out;
            s_out             <= s_out;
            status_out        <= status_out;
            valid_out         <= valid_out;
            is_mem_out        <= is_mem_out;
        end
    end

`ifdef ID_EXE_FWD_SRC_EN
    // Source register numbers for forwarding. They are cleared on a bubble so
    // that the forwarding unit never matches against an instruction that
    // does not exist.
    logic [3:0] ld_src1_s;
    logic [3:0] ld_src2_s;

    // Clear the source numbers when no real instruction is loaded.
    always_comb begin
        ld_src1_s = 4'd0;
        ld_src2_s = 4'd0;
        if (valid_in) begin
            ld_src1_s = src1_in;
            ld_src2_s = src2_in;
        end else begin
            ld_src1_s = 4'd0;
            ld_src2_s = 4'd0;
        end
    end

    // Source-number register, with the same priority as the main register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            src1_out <= 4'd0;
            src2_out <= 4'd0;
        end else if (!freeze) begin
            src1_out <= ld_src1_s;
            src2_out <= ld_src2_s;
        end else begin
            src1_out <= src1_out;
            src2_out <= src2_out;
        end
    end
`else
    // With forwarding disabled, the source numbers are ignored.
    logic unused_src_s;
    assign unused_src_s = ^{src1_in, src2_in};
    assign src1_out     = 4'd0;
    assign src2_out     = 4'd0;
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_exe_pipe_reg
//
// Directed testbench for id_exe_pipe_reg. Inputs are driven 1 time unit after
// each rising edge. Outputs are checked 1 time unit after the next rising
// edge, so each step covers exactly one register update.
// -----------------------------------------------------------------------------
module tb_id_exe_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, valid_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic        imm_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in, exe_cmd_in, status_in, src1_in, src2_in;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in;

    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_operand_out;
    logic        imm_out;
    logic [23:0] signed_imm_24_out;
    logic [3:0]  dest_out, exe_cmd_out, status_out, src1_out, src2_out;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
    logic        valid_out, is_mem_out;

    int n_vec = 0;
    int n_bad = 0;
    logic [3:0] exp_src1, exp_src2;

    always #5 clk = ~clk;

    id_exe_pipe_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .imm_in(imm_in),
        .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .exe_cmd_in(exe_cmd_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
        .b_in(b_in), .s_in(s_in), .status_in(status_in),
        .src1_in(src1_in), .src2_in(src2_in),
        .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .shift_operand_out(shift_operand_out), .imm_out(imm_out),
        .signed_imm_24_out(signed_imm_24_out), .dest_out(dest_out),
        .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out), .b_out(b_out),
        .s_out(s_out), .status_out(status_out), .valid_out(valid_out),
        .is_mem_out(is_mem_out), .src1_out(src1_out), .src2_out(src2_out)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check every output against zero. The outputs are concatenated into one
    // vector so that the message shows which bits are wrong.
    task automatic check_zero(input string tag);
        check(tag, {pc_out, val_rn_out, val_rm_out, shift_operand_out, imm_out,
                    signed_imm_24_out, dest_out, exe_cmd_out, mem_r_en_out,
                    mem_w_en_out, wb_en_out, b_out, s_out, status_out,
                    valid_out, is_mem_out, src1_out, src2_out}, 160'd0);
    endtask

    // Check the control bits in the order {wb, mem_r, mem_w, b, s, is_mem, valid}.
    task automatic check_ctl(input string tag, input logic [6:0] exp);
        check(tag, {153'd0, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out,
                    is_mem_out, valid_out}, {153'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in = 1'b0; pc_in = 32'd0; val_rn_in = 32'd0; val_rm_in = 32'd0;
        shift_operand_in = 12'd0; imm_in = 1'b0; signed_imm_24_in = 24'd0;
        dest_in = 4'd0; exe_cmd_in = 4'd0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        wb_en_in = 1'b0; b_in = 1'b0; s_in = 1'b0; status_in = 4'd0;
        src1_in = 4'd0; src2_in = 4'd0;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        clear_inputs();
        // Drive nonzero inputs during reset to show that reset overrides them.
        valid_in = 1'b1; pc_in = 32'hDEAD_BEEF; val_rn_in = 32'h5555_AAAA;
        mem_r_en_in = 1'b1; wb_en_in = 1'b1; status_in = 4'hF; exe_cmd_in = 4'h7;
        src1_in = 4'h6; src2_in = 4'h9;
        #1;

        // Reset for two cycles.
        step(); check_zero("reset_c1");
        step(); check_zero("reset_c2");

        // Release reset. The first load happens on the first edge with rst low.
        rst = 1'b0;
        clear_inputs();
        valid_in = 1'b1; pc_in = 32'h0000_0010; val_rm_in = 32'h8000_0001;
        shift_operand_in = 12'h3E2; wb_en_in = 1'b1;
        step();
        check("rel_pc",    {128'd0, pc_out},            {128'd0, 32'h0000_0010});
        check("rel_val_rm",{128'd0, val_rm_out},        {128'd0, 32'h8000_0001});
        check("rel_shop",  {148'd0, shift_operand_out}, {148'd0, 12'h3E2});
        check_ctl("rel_ctl", 7'b1000001);

        // Freeze hold. Load A, then hold it for 3 cycles while the inputs change to B.
        clear_inputs();
        valid_in = 1'b1; exe_cmd_in = 4'b0010; pc_in = 32'h0000_0100;
        val_rn_in = 32'hAAAA_0001; status_in = 4'h9; dest_in = 4'h5; mem_r_en_in = 1'b1;
        step();
        check("A_load", {120'd0, exe_cmd_out, pc_out, dest_out},
                        {120'd0, 4'b0010, 32'h0000_0100, 4'h5});
        check_ctl("A_ctl", 7'b0100011);
        freeze = 1'b1;
        clear_inputs();
        valid_in = 1'b1; exe_cmd_in = 4'hC; pc_in = 32'h0000_0200;
        val_rn_in = 32'hBBBB_0002; status_in = 4'h4; dest_in = 4'hE; wb_en_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_hold", {88'd0, exe_cmd_out, pc_out, val_rn_out, status_out},
                              {88'd0, 4'b0010, 32'h0000_0100, 32'hAAAA_0001, 4'h9});
            check_ctl("frz_ctl", 7'b0100011);
        end
        freeze = 1'b0;
        step();
        check("B_load", {88'd0, exe_cmd_out, pc_out, val_rn_out, status_out},
                        {88'd0, 4'hC, 32'h0000_0200, 32'hBBBB_0002, 4'h4});
        check_ctl("B_ctl", 7'b1000001);

        // Flush a store. The bubble clears both the control bits and the data fields.
        clear_inputs();
        valid_in = 1'b1; mem_w_en_in = 1'b1; pc_in = 32'h0000_0300;
        val_rn_in = 32'hCAFE_0000; status_in = 4'h2; flush = 1'b1;
        step(); check_zero("flush_store");
        flush = 1'b0;

        // Flush and freeze together. First load A and hold it.
        clear_inputs();
        valid_in = 1'b1; exe_cmd_in = 4'b0010; pc_in = 32'h0000_0400;
        wb_en_in = 1'b1; b_in = 1'b1; s_in = 1'b1;
        step();
        check_ctl("A2_ctl", 7'b1001101);
        freeze = 1'b1;
        pc_in = 32'h0000_0404;
        step();
        check("A2_hold", {128'd0, pc_out}, {128'd0, 32'h0000_0400});
        flush = 1'b1;
        step(); check_zero("flush_frz");
        flush = 1'b0;
        step(); check_zero("flush_frz_hold");
        freeze = 1'b0;

        // Bubble load. The control bits are cleared and the data fields still load.
        clear_inputs();
        valid_in = 1'b0; mem_r_en_in = 1'b1; wb_en_in = 1'b1; b_in = 1'b1; s_in = 1'b1;
        val_rn_in = 32'h1234_5678; pc_in = 32'h0000_0500; src1_in = 4'hA; src2_in = 4'h3;
        step();
        check("bub_val_rn", {128'd0, val_rn_out}, {128'd0, 32'h1234_5678});
        check("bub_pc",     {128'd0, pc_out},     {128'd0, 32'h0000_0500});
        check_ctl("bub_ctl", 7'b0000000);
        check("bub_src", {152'd0, src1_out, src2_out}, 160'd0);

        // Source numbers with the immediate fields passed through unchanged.
        clear_inputs();
        valid_in = 1'b1; src1_in = 4'hA; src2_in = 4'h3; imm_in = 1'b1;
        signed_imm_24_in = 24'hFF_FFFE; b_in = 1'b1;
`ifdef ID_EXE_FWD_SRC_EN
        exp_src1 = 4'hA; exp_src2 = 4'h3;
`else
        exp_src1 = 4'h0; exp_src2 = 4'h0;
`endif
        step();
        check("src_fwd", {152'd0, src1_out, src2_out}, {152'd0, exp_src1, exp_src2});
        check("imm_pass", {135'd0, imm_out, signed_imm_24_out}, {135'd0, 1'b1, 24'hFF_FFFE});
        check_ctl("br_ctl", 7'b0001001);

        // Reset while frozen. The bubble is inserted at once and freeze then holds it.
        freeze = 1'b1; rst = 1'b1;
        step(); check_zero("rst_frz");
        rst = 1'b0;
        step(); check_zero("rst_frz_hold");
        freeze = 1'b0;
        step();
        check("post_frz_src", {152'd0, src1_out, src2_out}, {152'd0, exp_src1, exp_src2});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_exe_pipe_reg.md
Name: id_exe_pipe_reg

Overview:
- Pipeline register between the Instruction Decode stage and the Execution stage.
- Captures the decoded control bits, operand values, shifter operand and branch immediate at each clock edge.
- Drives the Execution-stage inputs (Val2 generation, ALU, branch adder) for one cycle.
- Supports freeze (hazard stall), flush (taken branch) and a valid bit so that downstream stages can ignore bubbles.

Parameters:
- DATA_W, 32, width of PC and operand values.
- SHOP_W, 12, width of the shifter-operand field.
- IMM24_W, 24, width of the branch signed immediate.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- freeze  in  1  hazard stall; hold all registered outputs.
- flush  in  1  taken-branch squash; insert a bubble.
- valid_in  in  1  ID stage holds a real instruction.
- pc_in  in  32  PC+4 of the ID instruction.
- val_rn_in  in  32  register-file Rn value.
- val_rm_in  in  32  register-file Rm value.
- shift_operand_in  in  12  instruction bits [11:0].
- imm_in  in  1  I bit (immediate operand).
- signed_imm_24_in  in  24  branch offset field.
- dest_in  in  4  destination register number.
- exe_cmd_in  in  4  ALU command.
- mem_r_en_in  in  1  load.
- mem_w_en_in  in  1  store.
- wb_en_in  in  1  write-back enable.
- b_in  in  1  branch.
- s_in  in  1  update status.
- status_in  in  4  current NZCV.
- src1_in  in  4  Rn number (used only with the optional feature).
- src2_in  in  4  Rm/Rd number (used only with the optional feature).
- The registered counterparts pc, val_rn, val_rm, shift_operand, imm, signed_imm_24, dest, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, status and valid are all outputs. Each has the same width as its input, and its name is the input name with "_in" replaced by "_out".
- is_mem_out  out  1  registered (mem_r_en_in | mem_w_en_in).
- src1_out, src2_out  out  4 each  registered source register numbers.

Behaviour:
- All outputs are registers. Latency is 1 cycle from inputs to outputs. No combinational path from input to output.
- Per-edge priority: rst > flush > freeze > load.
- rst = 1: every output becomes 0, including valid_out, is_mem_out and status_out.
- flush = 1 (no rst): every output becomes 0, which is a bubble.
  - flush wins over freeze when both are asserted in the same cycle.
  - A bubble must never carry wb_en, mem_r_en, mem_w_en, b or s.
- freeze = 1 (no rst, no flush): all outputs hold their previous values, including valid_out.
- Otherwise (load): every output takes its input.
  - If valid_in = 0, the register loads a bubble: all control outputs (wb_en, mem_r_en, mem_w_en, b, s, is_mem, valid) are 0. The data fields still load the input values.
- is_mem_out must equal mem_r_en_out | mem_w_en_out in every cycle.
- There is no width conversion. Fields pass bit-exact. status_out is the NZCV sampled in the same cycle as the instruction.
- Reset or flush asserted while freeze is high: the bubble is inserted immediately, and freeze then holds that bubble.
- Reset deassertion: the first load happens on the first edge with rst = 0.

Optional Feature:
- Macro: ID_EXE_FWD_SRC_EN.
- Defined:
  - src1_out and src2_out follow the same rst/flush/freeze/load rules as the data fields.
  - On a bubble load (valid_in = 0), src1_out and src2_out are forced to 0.
- Undefined:
  - src1_out and src2_out are constant 0.
  - src1_in and src2_in are ignored. No flops are inferred for them.

Test Plan:
- Reset then load: rst = 1 for 2 cycles, then release with valid_in = 1, pc_in = 0x0000_0010, val_rm_in = 0x8000_0001, shift_operand_in = 0x3E2, wb_en_in = 1. Required: all outputs are 0 during reset; 1 cycle after release, pc_out = 0x10, val_rm_out = 0x8000_0001, shift_operand_out = 0x3E2, wb_en_out = 1, valid_out = 1.
- Freeze hold: load instruction A (exe_cmd_in = 4'b0010), then freeze = 1 for 3 cycles while the inputs change to B. Required: outputs stay A for the 3 cycles and become B on the edge after freeze drops.
- Flush: load a store (mem_w_en_in = 1, valid_in = 1) with flush = 1. Required: next cycle mem_w_en_out = 0, is_mem_out = 0, valid_out = 0, and all data outputs are 0.
- Flush and freeze together: A is held, then freeze = 1 and flush = 1 in the same cycle. Required: a bubble appears (all 0). With freeze still held, the bubble persists.
- Bubble load: valid_in = 0, mem_r_en_in = 1, val_rn_in = 0x1234_5678. Required: mem_r_en_out = 0, is_mem_out = 0, valid_out = 0, val_rn_out = 0x1234_5678.
- Feature check: src1_in = 4'hA, src2_in = 4'h3. Required with ID_EXE_FWD_SRC_EN defined: src1_out = 4'hA and src2_out = 4'h3 next cycle. Required with it undefined: both are 0.
